// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: CPU clock-enable generator with run/divide/single-step modes,
// a debounced step key, and a PC breakpoint that halts into single-step.
module cpu_clock_ctrl #(
  parameter int DIV_W      = 24,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 32,
  parameter int DEB_CYCLES = 50000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div_sel,
  input  logic              step_key,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_enable,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              resume,
  output logic              cpu_en,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam logic [1:0] M_RUN  = 2'b00;
  localparam logic [1:0] M_DIV  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

  typedef enum logic {ACTIVE, BREAK} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic               deb_q, deb_d;
  logic [DCW-1:0]     dcnt_q, dcnt_d;
  logic               load_q;
  logic [1:0]         mode_q;
  logic [DIV_W-1:0]   div_q, div_d, div_cur;
  logic               tick, press, bp_hit;
  logic               armed_q, armed_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   cnt_q;

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync_q[1] != deb_q) begin
      dcnt_d = dcnt_q + 1'b1;
      if (dcnt_q == DCW'(DEB_CYCLES - 1)) begin
        deb_d  = sync_q[1];
        dcnt_d = '0;
      end
    end
  end

  // Press fires on the cycle the debounced level is about to fall, so it
  // lands in cpu_en on the same edge that deb_q goes low.
  assign press = deb_q & ~deb_d;

  // load_q stands in for "divider holds div_sel" while and right after reset.
  assign div_cur = (load_q || mode != mode_q) ? div_sel : div_q;
  assign tick    = (div_cur == '0);
  assign div_d   = tick ? div_sel : div_cur - 1'b1;

  assign bp_hit = bp_enable & armed_q & (pc == bp_addr);

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    armed_d = armed_q | (pc != bp_addr);
    if (state_q == ACTIVE) begin
      if (bp_hit) begin
        state_d = BREAK;
        armed_d = 1'b0;
      end else begin
        en_d = (mode == M_RUN)  ? 1'b1 :
               (mode == M_DIV)  ? tick :
               (mode == M_STEP) ? press : 1'b0;
      end
    end else begin
      en_d = press;
      if (resume) state_d = ACTIVE;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= ACTIVE;
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      load_q  <= 1'b1;
      mode_q  <= M_RUN;
      div_q   <= '0;
      armed_q <= 1'b0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], step_key};
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      load_q  <= 1'b0;
      mode_q  <= mode;
      div_q   <= div_d;
      armed_q <= armed_d;
      en_q    <= en_d;
      cnt_q   <= cnt_q + CNT_W'(en_d);
    end
  end

  assign cpu_en      = en_q;
  assign halted      = (state_q == BREAK);
  assign cycle_count = cnt_q;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed checks of run/divide/step/hold, breakpoint, wrap and reset.
module tb_cpu_clock_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [23:0] div_sel;
  logic        step_key;
  logic [15:0] pc;
  logic        bp_enable;
  logic [15:0] bp_addr;
  logic        resume;
  logic        cpu_en, halted, en4, halt4;
  logic [31:0] cycle_count;
  logic [3:0]  cnt4;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;

  always #5 clk = ~clk;

  cpu_clock_ctrl #(.DEB_CYCLES(8)) dut (
    .CLOCK_50(clk), .reset(reset), .mode(mode), .div_sel(div_sel), .step_key(step_key),
    .pc(pc), .bp_enable(bp_enable), .bp_addr(bp_addr), .resume(resume),
    .cpu_en(cpu_en), .halted(halted), .cycle_count(cycle_count)
  );

  cpu_clock_ctrl #(.DEB_CYCLES(8), .CNT_W(4)) dut4 (
    .CLOCK_50(clk), .reset(reset), .mode(mode), .div_sel(div_sel), .step_key(step_key),
    .pc(pc), .bp_enable(bp_enable), .bp_addr(bp_addr), .resume(resume),
    .cpu_en(en4), .halted(halt4), .cycle_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic v, input int n);
    step_key = v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cpu_en) pulses++;
    end
  endtask

  initial begin
    reset = 1'b0; mode = 2'b00; div_sel = 24'd3; step_key = 1'b1;
    pc = 16'h0000; bp_enable = 1'b0; bp_addr = 16'h0010; resume = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_en", cpu_en, 0);
    chk("rst_halt", halted, 0);
    chk("rst_cnt", cycle_count, 0);
    reset = 1'b1;
    #1 chk("rel_en", cpu_en, 0);
    // Scenario 1: RUN
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("run_en", cpu_en, 1);
    end
    chk("run_cnt", cycle_count, 100);
    chk("run_cnt4", cnt4, 4);
    // Scenario 2: DIV by 4, then div_sel=0 with a mode toggle
    mode = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("div3_en", cpu_en, (k % 4) == 0);
    end
    div_sel = 24'd0; mode = 2'b00;
    @(negedge clk);
    chk("div0_en", cpu_en, 1);
    mode = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("div0_en", cpu_en, 1);
    end
    chk("div_cnt", cycle_count, 109);
    mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_en", cpu_en, 0);
    end
    chk("hold_cnt", cycle_count, 109);
    // Scenario 3: STEP with bounces
    mode = 2'b10;
    repeat (2) @(negedge clk);
    chk("step_idle", cpu_en, 0);
    pulses = 0;
    key(0, 3); key(1, 3); key(0, 3); key(1, 3); key(0, 20);
    chk("step_press", pulses, 1);
    pulses = 0;
    key(1, 3); key(0, 3); key(1, 20);
    chk("step_release", pulses, 0);
    chk("step_cnt", cycle_count, 110);
    // Scenario 4: breakpoint at 0x0010
    mode = 2'b00; bp_enable = 1'b1; pc = 16'h0000;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("bp_run_en", cpu_en, 1);
      chk("bp_run_halt", halted, 0);
      pc = 16'(i);
    end
    @(negedge clk);
    chk("bp_halt", halted, 1);
    chk("bp_hit_en", cpu_en, 0);
    chk("bp_cnt", cycle_count, 126);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("brk_idle_en", cpu_en, 0);
    end
    pulses = 0;
    key(0, 15); key(1, 15); key(0, 15); key(1, 15);
    chk("brk_presses", pulses, 2);
    chk("brk_still_halt", halted, 1);
    chk("brk_cnt", cycle_count, 128);
    // Press and resume in the same cycle
    step_key = 1'b0;
    repeat (9) @(negedge clk);
    chk("pr_pre_en", cpu_en, 0);
    resume = 1'b1;
    @(negedge clk);
    chk("pr_en", cpu_en, 1);
    chk("pr_halt", halted, 0);
    resume = 1'b0; step_key = 1'b1;
    chk("pr_cnt", cycle_count, 129);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("resume_run", cpu_en, 1);
      chk("no_rehalt", halted, 0);
    end
    pc = 16'h0011;
    @(negedge clk);
    pc = 16'h0010;
    @(negedge clk);
    chk("rehalt", halted, 1);
    chk("rehalt_en", cpu_en, 0);
    // Scenario 5: reset while in BREAK, then wrap of a 4-bit count
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_brk_halt", halted, 0);
    chk("rst_brk_cnt", cycle_count, 0);
    chk("rst_brk_cnt4", cnt4, 0);
    chk("rst_brk_en", cpu_en, 0);
    bp_enable = 1'b0; pc = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    chk("rel2_en", cpu_en, 0);
    repeat (17) @(negedge clk);
    chk("wrap_cnt4", cnt4, 1);
    chk("wrap_cnt", cycle_count, 17);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
